multi_operand_seq_adder: RTL and testbench

Sequential multi-operand accumulator that sits directly upstream of the existing 8-bit ripple adder, `adder8`. It accepts a stream of 8-bit unsigned operands over a valid/ready handshake. Each operand is added to a running sum through one `adder8` instance, which handles the low byte. The carry-out increments the upper accumulator bits. When the operand flagged last is accepted, the block presents the wide sum, beat count and overflow flag on a second valid/ready handshake.

---
 rtl/moa_pkg.sv | 22 ++
 rtl/adder8.sv | 31 +++
 rtl/multi_operand_seq_adder.sv | 136 +++++++++++++
 tb/tb_multi_operand_seq_adder.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/moa_pkg.sv
// Shared types and width helpers for the multi-operand sequential adder.
// Build option: MOA_SAT_EN selects saturating accumulation on upper-bit wrap.
package moa_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } moa_state_e;

    localparam int MOA_N_MAX_DEF = 8;

    // Accumulator width: one byte plus room for N_MAX carries.
    function automatic int moa_acc_w(input int n_max);
        return 8 + $clog2(n_max);
    endfunction

    // Beat counter width: holds N_MAX+1 with one bit of headroom.
    function automatic int moa_cnt_w(input int n_max);
        return $clog2(n_max + 1) + 1;
    endfunction

endpackage

// File: rtl/adder8.sv
// 8-bit ripple-carry adder used for the low byte of the accumulator.
// Also reports signed overflow, which the accumulator does not consume.
module adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co,
    output logic       of
);

    logic c;
    logic c7;

    // Ripple the carry bit by bit, remembering the carry into the msb.
    always_comb begin
        s  = '0;
        c  = ci;
        c7 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                c7 = c;
            end
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
        of = c7 ^ c;
    end

endmodule

// File: rtl/multi_operand_seq_adder.sv
// Streams 8-bit operands into a wide running sum; emits sum/count/ovf on last.
// Build option: MOA_SAT_EN clamps the sum at all-ones after an upper-bit wrap.
module multi_operand_seq_adder
    import moa_pkg::*;
#(
    parameter int N_MAX = MOA_N_MAX_DEF,
    parameter int ACC_W = moa_acc_w(N_MAX),
    parameter int CNT_W = moa_cnt_w(N_MAX)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    localparam int HI_W = ACC_W - 8;

    moa_state_e       state_q;
    moa_state_e       state_d;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             ovf_q;
    logic             ovf_d;

    logic [7:0]       add_s;
    logic             add_co;
    logic             add_of_unused;
    logic [HI_W-1:0]  hi_nxt;
    logic             hi_wrap;
    logic             beat;
    logic             cnt_hit;

`ifdef MOA_SAT_EN
    logic             sat_q;
    logic             sat_d;
`endif

    adder8 u_adder8 (
        .a  (acc_q[7:0]),
        .b  (in_data),
        .ci (1'b0),
        .s  (add_s),
        .co (add_co),
        .of (add_of_unused)
    );

    assign {hi_wrap, hi_nxt} = {1'b0, acc_q[ACC_W-1:8]}
                             + {{HI_W{1'b0}}, add_co};

    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q
                                               : cnt_q + CNT_W'(1);
    assign cnt_hit = (cnt_inc == CNT_W'(N_MAX + 1));

    assign in_ready  = rst_n & (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign out_sum   = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;

    assign beat = in_valid & in_ready;

    // Next-state: accumulate beats in ACCUM, clear on output handshake.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
`ifdef MOA_SAT_EN
        sat_d   = sat_q;
`endif
        if (state_q == DONE) begin
            if (out_ready) begin
                state_d = ACCUM;
                acc_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
`ifdef MOA_SAT_EN
                sat_d   = 1'b0;
`endif
            end
        end else if (beat) begin
`ifdef MOA_SAT_EN
            if (sat_q || hi_wrap) begin
                acc_d = '1;
                sat_d = 1'b1;
            end else begin
                acc_d = {hi_nxt, add_s};
            end
`else
            acc_d = {hi_nxt, add_s};
`endif
            cnt_d = cnt_inc;
            ovf_d = ovf_q | hi_wrap | cnt_hit;
            if (in_last) begin
                state_d = DONE;
            end
        end
    end

    // Sequence state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef MOA_SAT_EN
    // Remembers that the sum clamped, so later beats keep it clamped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end
`endif

endmodule

// File: tb/tb_multi_operand_seq_adder.sv
// Scoreboard bench for multi_operand_seq_adder.
// Expected results come from an arithmetic model of each operand list.
module tb_multi_operand_seq_adder;

    localparam int N_MAX = 8;
    localparam int ACC_W = 11;
    localparam int CNT_W = 5;
    localparam int SUM_MAX = (1 << ACC_W) - 1;

    typedef struct {
        logic [ACC_W-1:0] sum;
        logic [CNT_W-1:0] count;
        logic             ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_data = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    multi_operand_seq_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    function automatic exp_t model(input int ops[$]);
        exp_t e;
        int total;
        total = 0;
        foreach (ops[i]) total += ops[i];
`ifdef MOA_SAT_EN
        e.sum = (total > SUM_MAX) ? ACC_W'(SUM_MAX) : ACC_W'(total);
`else
        e.sum = ACC_W'(total % (SUM_MAX + 1));
`endif
        e.count = CNT_W'(ops.size());
        e.ovf = (ops.size() > N_MAX) || (total > SUM_MAX);
        return e;
    endfunction

    // Drives one sequence from a negedge; returns on the negedge after
    // the last beat is accepted. waited = stall cycles before beat 0.
    task automatic send(input int ops[$], output int waited);
        int w;
        sb.push_back(model(ops));
        waited = 0;
        foreach (ops[i]) begin
            in_valid = 1'b1;
            in_data  = 8'(ops[i]);
            in_last  = (i == ops.size() - 1);
            w = 0;
            while (!in_ready && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (i == 0) waited = w;
            if (!in_ready) begin
                vectors++;
                miscompares++;
                $display("FAIL send_ready timeout in_ready=%b want 1", in_ready);
            end
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom_range(0, 255));
        end
        in_last = 1'b0;
    endtask

    task automatic await_out(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        vectors++;
        if ({in_ready, out_valid, out_sum, out_count, out_ovf} !== '0) begin
            miscompares++;
            $display("FAIL reset_outs got rdy=%b vld=%b sum=%0d cnt=%0d ovf=%b want all 0",
                     in_ready, out_valid, out_sum, out_count, out_ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release got rdy=%b vld=%b want 1 0",
                     in_ready, out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        int q[$];
        int w;
        bit ok;
        exp_t e;
        out_ready = 1'b1;
        q = '{5, 10, 37, 48};
        send(q, w);
        await_out(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL basic_valid timeout got 0 want 1");
        end
        e = sb.pop_front();
        vectors++;
        if (out_sum !== e.sum || out_count !== e.count || out_ovf !== e.ovf) begin
            miscompares++;
            $display("FAIL basic_result got %0d/%0d/%b want %0d/%0d/%b",
                     out_sum, out_count, out_ovf, e.sum, e.count, e.ovf);
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_busy in_ready got %b want 0", in_ready);
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== '0) begin
            miscompares++;
            $display("FAIL basic_after got vld=%b rdy=%b cnt=%0d want 0 1 0",
                     out_valid, in_ready, out_count);
        end
    endtask

    task automatic test_carry();
        int q[$];
        int w;
        bit ok;
        exp_t e;
        out_ready = 1'b1;
        q = '{255, 255, 255, 255, 255, 255, 255, 255};
        send(q, w);
        await_out(ok);
        e = sb.pop_front();
        vectors++;
        if (!ok || out_sum !== e.sum || out_count !== e.count || out_ovf !== e.ovf) begin
            miscompares++;
            $display("FAIL carry_result got %0d/%0d/%b vld=%b want %0d/%0d/%b",
                     out_sum, out_count, out_ovf, ok, e.sum, e.count, e.ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        int q[$];
        int w;
        bit ok;
        exp_t e;
        out_ready = 1'b1;
        q = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
        send(q, w);
        await_out(ok);
        e = sb.pop_front();
        vectors++;
        if (!ok || out_sum !== e.sum) begin
            miscompares++;
            $display("FAIL ovf_sum got %0d want %0d", out_sum, e.sum);
        end
        vectors++;
        if (out_count !== e.count || out_ovf !== e.ovf) begin
            miscompares++;
            $display("FAIL ovf_flags got %0d/%b want %0d/%b",
                     out_count, out_ovf, e.count, e.ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        int q[$];
        int w;
        bit ok;
        exp_t e;
        out_ready = 1'b0;
        q = '{127};
        send(q, w);
        await_out(ok);
        e = sb.pop_front();
        in_valid = 1'b1;
        in_data  = 8'd200;
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (!ok || out_valid !== 1'b1 || in_ready !== 1'b0 ||
                out_sum !== e.sum || out_count !== e.count || out_ovf !== e.ovf) begin
                miscompares++;
                $display("FAIL stall_hold c=%0d got vld=%b rdy=%b %0d/%0d/%b want 1 0 %0d/%0d/%b",
                         c, out_valid, in_ready, out_sum, out_count, out_ovf,
                         e.sum, e.count, e.ovf);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || out_sum !== '0 || out_count !== '0) begin
            miscompares++;
            $display("FAIL stall_release got vld=%b sum=%0d cnt=%0d want 0 0 0",
                     out_valid, out_sum, out_count);
        end
    endtask

    task automatic test_gaps();
        int q[$];
        int run;
        bit ok;
        exp_t e;
        out_ready = 1'b1;
        q = '{125, 110, 63};
        sb.push_back(model(q));
        run = 0;
        foreach (q[i]) begin
            in_valid = 1'b1;
            in_data  = 8'(q[i]);
            in_last  = (i == q.size() - 1);
            @(posedge clk);
            @(negedge clk);
            run += q[i];
            in_valid = 1'b0;
            in_data  = 8'($urandom_range(0, 255));
            in_last  = 1'b1;
            if (i != q.size() - 1) begin
                for (int g = 0; g < 2; g++) begin
                    vectors++;
                    if (out_sum !== ACC_W'(run) || out_count !== CNT_W'(i + 1)) begin
                        miscompares++;
                        $display("FAIL gap_idle got %0d/%0d want %0d/%0d",
                                 out_sum, out_count, run, i + 1);
                    end
                    @(negedge clk);
                end
            end
        end
        in_last = 1'b0;
        await_out(ok);
        e = sb.pop_front();
        vectors++;
        if (!ok || out_sum !== e.sum || out_count !== e.count || out_ovf !== e.ovf) begin
            miscompares++;
            $display("FAIL gap_result got %0d/%0d/%b want %0d/%0d/%b",
                     out_sum, out_count, out_ovf, e.sum, e.count, e.ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int q[$];
        int w;
        bit ok;
        exp_t e;
        out_ready = 1'b1;
        q = '{1, 2, 3};
        send(q, w);
        await_out(ok);
        e = sb.pop_front();
        vectors++;
        if (!ok || out_sum !== e.sum || out_count !== e.count) begin
            miscompares++;
            $display("FAIL b2b_first got %0d/%0d want %0d/%0d",
                     out_sum, out_count, e.sum, e.count);
        end
        q = '{200, 4};
        send(q, w);
        vectors++;
        if (w !== 1) begin
            miscompares++;
            $display("FAIL b2b_bubble got %0d cycles want 1", w);
        end
        await_out(ok);
        e = sb.pop_front();
        vectors++;
        if (!ok || out_sum !== e.sum || out_count !== e.count || out_ovf !== e.ovf) begin
            miscompares++;
            $display("FAIL b2b_second got %0d/%0d/%b want %0d/%0d/%b",
                     out_sum, out_count, out_ovf, e.sum, e.count, e.ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int q[$];
        int w;
        bit ok;
        exp_t e;
        out_ready = 1'b1;
        q = '{100, 200};
        foreach (q[i]) begin
            in_valid = 1'b1;
            in_data  = 8'(q[i]);
            in_last  = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        vectors++;
        if (out_sum !== 11'd300 || out_count !== 5'd2) begin
            miscompares++;
            $display("FAIL mid_partial got %0d/%0d want 300/2", out_sum, out_count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({in_ready, out_valid, out_sum, out_count, out_ovf} !== '0) begin
            miscompares++;
            $display("FAIL mid_async got rdy=%b vld=%b sum=%0d cnt=%0d ovf=%b want all 0",
                     in_ready, out_valid, out_sum, out_count, out_ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_release in_ready got %b want 1", in_ready);
        end
        @(negedge clk);
        q = '{3, 90};
        send(q, w);
        await_out(ok);
        e = sb.pop_front();
        vectors++;
        if (!ok || out_sum !== e.sum || out_count !== e.count || out_ovf !== e.ovf) begin
            miscompares++;
            $display("FAIL mid_after got %0d/%0d/%b want %0d/%0d/%b",
                     out_sum, out_count, out_ovf, e.sum, e.count, e.ovf);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_overflow();
        test_stall();
        test_gaps();
        test_back_to_back();
        test_mid_reset();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_left got %0d entries want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
